// File: rtl/sysbus_mem_responder_if.sv
// Request/response system bus between the core's arbiter (master) and a memory responder (slave).
interface sysbus_mem_responder_if #(
  parameter int DW = 64,
  parameter int TW = 13
) ();
  logic          bus_reqcyc;
  logic [DW-1:0] bus_req;
  logic [TW-1:0] bus_reqtag;
  logic          bus_reqack;
  logic          bus_respcyc;
  logic [DW-1:0] bus_resp;
  logic [TW-1:0] bus_resptag;
  logic          bus_respack;

  modport master (
    output bus_reqcyc, bus_req, bus_reqtag, bus_respack,
    input  bus_reqack, bus_respcyc, bus_resp, bus_resptag
  );

  modport slave (
    input  bus_reqcyc, bus_req, bus_reqtag, bus_respack,
    output bus_reqack, bus_respcyc, bus_resp, bus_resptag
  );
endinterface

// File: rtl/sysbus_mem_responder.sv
// Memory-side system-bus responder: 64-byte line reads returned as 8 tagged beats,
// 64-byte line writes absorbed as 8 data beats, plus a backdoor preload port.
module sysbus_mem_responder #(
  parameter int         BUS_DATA_WIDTH = 64,
  parameter int         BUS_TAG_WIDTH  = 13,
  parameter logic [3:0] MEM_DEVICE     = 4'b0001,
  parameter int         MEM_WORDS      = 4096,
  parameter int         READ_LATENCY   = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  sysbus_mem_responder_if.slave        bus,
  input  logic                         init_we,
  input  logic [$clog2(MEM_WORDS)-1:0] init_addr,
  input  logic [BUS_DATA_WIDTH-1:0]    init_data
);
  localparam int AW = $clog2(MEM_WORDS);
  localparam int BW = AW - 3;
  localparam int LW = $clog2(READ_LATENCY + 1);

  typedef enum logic [1:0] {IDLE, RD_WAIT, RD_RESP, WR_DATA} state_t;

  state_t                    state_q;
  logic [LW-1:0]             lat_q;
  logic [2:0]                beat_q;
  logic [BW-1:0]             base_q;
  logic [BUS_TAG_WIDTH-1:0]  tag_q;
  logic [BUS_TAG_WIDTH-1:0]  resptag_q;
  logic                      respcyc_q;
  logic [BUS_DATA_WIDTH-1:0] resp_q;
  logic [BUS_DATA_WIDTH-1:0] mem_q [MEM_WORDS];

  logic                      reqack;
  logic                      dev_match;
  logic                      wr_en;
  logic [BW-1:0]             req_base;
  logic [BW-1:0]             rd_base;
  logic [2:0]                rd_beat;
  logic [AW-1:0]             rd_addr;
  logic [AW-1:0]             wr_addr;
  logic [BUS_DATA_WIDTH-1:0] rd_word;

  // Only the low line-index bits survive: addresses past the array wrap.
  assign req_base  = bus.bus_req[6 +: BW];
  assign dev_match = bus.bus_reqtag[11:8] == MEM_DEVICE;
  assign reqack    = !reset && bus.bus_reqcyc &&
                     ((state_q == IDLE && dev_match) || state_q == WR_DATA);
  assign wr_en     = reqack && state_q == WR_DATA;
  assign wr_addr   = {base_q, beat_q};

  // Address of the word to be shown on bus_resp during the next cycle.
  always_comb begin
    rd_base = base_q;
    rd_beat = 3'd0;
    if (state_q == IDLE) begin
      rd_base = req_base;
    end else if (state_q == RD_RESP) begin
      rd_beat = bus.bus_respack ? beat_q + 3'd1 : beat_q;
    end
  end

  assign rd_addr = {rd_base, rd_beat};
  // Backdoor write forwarding so a word being driven reflects the update next cycle.
  assign rd_word = (init_we && init_addr == rd_addr) ? init_data : mem_q[rd_addr];

  // Bus write is the later assignment, so it wins a same-word collision.
  always_ff @(posedge clk) begin
    if (init_we) mem_q[init_addr] <= init_data;
    if (wr_en)   mem_q[wr_addr]   <= bus.bus_req;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      lat_q     <= '0;
      beat_q    <= '0;
      base_q    <= '0;
      tag_q     <= '0;
      respcyc_q <= 1'b0;
      resp_q    <= '0;
      resptag_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (reqack) begin
            base_q <= req_base;
            beat_q <= 3'd0;
            if (bus.bus_reqtag[12]) begin
              tag_q <= bus.bus_reqtag;
              lat_q <= LW'(READ_LATENCY - 1);
              if (READ_LATENCY == 1) begin
                state_q   <= RD_RESP;
                respcyc_q <= 1'b1;
                resp_q    <= rd_word;
                resptag_q <= bus.bus_reqtag;
              end else begin
                state_q <= RD_WAIT;
              end
            end else begin
              state_q <= WR_DATA;
            end
          end
        end
        RD_WAIT: begin
          lat_q <= lat_q - LW'(1);
          if (lat_q == LW'(1)) begin
            state_q   <= RD_RESP;
            respcyc_q <= 1'b1;
            resp_q    <= rd_word;
            resptag_q <= tag_q;
          end
        end
        RD_RESP: begin
          resp_q <= rd_word;
          if (bus.bus_respack) begin
            beat_q <= beat_q + 3'd1;
            if (beat_q == 3'd7) begin
              state_q   <= IDLE;
              respcyc_q <= 1'b0;
              resp_q    <= '0;
              resptag_q <= '0;
            end
          end
        end
        WR_DATA: begin
          if (reqack) begin
            beat_q <= beat_q + 3'd1;
            if (beat_q == 3'd7) state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.bus_reqack  = reqack;
  assign bus.bus_respcyc = respcyc_q;
  assign bus.bus_resp    = resp_q;
  assign bus.bus_resptag = resptag_q;
endmodule

// File: tb/tb_sysbus_mem_responder.sv
// Randomised bench for sysbus_mem_responder: a line-level memory model predicts every
// handshake and response beat, plus literal checks for the directed scenarios.
module tb_sysbus_mem_responder;
  localparam int L      = 4;
  localparam int WORDS  = 4096;
  localparam int M_FREE = 0;
  localparam int M_RD   = 1;
  localparam int M_WR   = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        init_we = 1'b0;
  logic [11:0] init_addr = '0;
  logic [63:0] init_data = '0;

  always #5 clk = ~clk;

  sysbus_mem_responder_if sb ();

  sysbus_mem_responder #(
    .BUS_DATA_WIDTH(64), .BUS_TAG_WIDTH(13), .MEM_DEVICE(4'b0001),
    .MEM_WORDS(WORDS), .READ_LATENCY(L)
  ) dut (
    .clk(clk), .reset(reset), .bus(sb),
    .init_we(init_we), .init_addr(init_addr), .init_data(init_data)
  );

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;

  // Line-level model state
  logic [63:0] mm [WORDS];
  int          mode = M_FREE;
  int          m_base = 0;
  int          acked = 0;
  int          wbeat = 0;
  int          acc_cyc = 0;
  logic [12:0] m_tag = '0;
  bit          synced = 1'b0;

  // Observations of the DUT for the directed literal checks
  logic [63:0] obs_data [$];
  logic [12:0] obs_tag [$];
  int obs_acks = 0, rc_cycles = 0, first_rc = -1, last_beat_cyc = -1, hold_cnt = 0;

  int          rp_mode = 0;
  int          stall_cnt = 0;
  bit          bd_rand = 1'b0;
  logic [75:0] pl_q [$];
  int          rd_ack_at = -1;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic int line_word(logic [63:0] a);
    longint unsigned lb;
    lb = a >> 6;
    return int'((lb * 8) % WORDS);
  endfunction

  function automatic int word_at(int base, int k);
    return (base + k) % WORDS;
  endfunction

  // Compare process: predict from the model, compare, then advance the model over the edge.
  initial begin
    logic e_ack, e_rc;
    forever begin
      @(negedge clk);
      if (reset) synced = 1'b1;
      e_ack = !reset && sb.bus_reqcyc &&
              ((mode == M_FREE && sb.bus_reqtag[11:8] == 4'h1) || mode == M_WR);
      e_rc  = (mode == M_RD) && (cyc >= acc_cyc + L);
      if (synced) begin
        check("reqack", 64'(sb.bus_reqack), 64'(e_ack));
        check("respcyc", 64'(sb.bus_respcyc), 64'(e_rc));
        if (e_rc) begin
          check("resp", sb.bus_resp, mm[word_at(m_base, acked)]);
          check("resptag", 64'(sb.bus_resptag), 64'(m_tag));
        end
      end
      if (sb.bus_reqack) obs_acks++;
      if (sb.bus_respcyc) begin
        rc_cycles++;
        if (first_rc < 0) first_rc = cyc;
        if (sb.bus_resp == 64'h1002) hold_cnt++;
      end
      if (sb.bus_respcyc && sb.bus_respack) begin
        obs_data.push_back(sb.bus_resp);
        obs_tag.push_back(sb.bus_resptag);
        if (obs_data.size() == 8) last_beat_cyc = cyc;
      end
      if (init_we) mm[init_addr] = init_data;
      if (reset) begin
        mode = M_FREE;
      end else begin
        if (e_ack) begin
          if (mode == M_WR) begin
            mm[word_at(m_base, wbeat)] = sb.bus_req;
            wbeat++;
            if (wbeat == 8) mode = M_FREE;
          end else begin
            m_base = line_word(sb.bus_req);
            if (sb.bus_reqtag[12]) begin
              mode = M_RD; m_tag = sb.bus_reqtag; acc_cyc = cyc; acked = 0;
            end else begin
              mode = M_WR; wbeat = 0;
            end
          end
        end
        if (e_rc && sb.bus_respack) begin
          acked++;
          if (acked == 8) mode = M_FREE;
        end
      end
    end
  end

  // Drives respack and the backdoor port just after each rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (rp_mode)
        1: sb.bus_respack = 1'($urandom_range(0, 1));
        2: begin
          if (sb.bus_respcyc && acked == 2 && stall_cnt < 3) begin
            sb.bus_respack = 1'b0;
            stall_cnt++;
          end else begin
            sb.bus_respack = 1'b1;
          end
        end
        default: sb.bus_respack = 1'b1;
      endcase
      if (pl_q.size() != 0) begin
        {init_addr, init_data} = pl_q.pop_front();
        init_we = 1'b1;
      end else if (bd_rand && $urandom_range(0, 3) == 0) begin
        init_we   = 1'b1;
        init_addr = 12'(word_at(m_base, int'($urandom_range(0, 7))));
        init_data = {$urandom, $urandom};
      end else begin
        init_we = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_obs();
    obs_data.delete(); obs_tag.delete();
    obs_acks = 0; rc_cycles = 0; first_rc = -1; last_beat_cyc = -1; hold_cnt = 0;
  endtask

  task automatic send_beat(input logic [63:0] d, input logic [12:0] t, output int ack_at);
    sb.bus_reqcyc = 1'b1; sb.bus_req = d; sb.bus_reqtag = t;
    ack_at = -1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (sb.bus_reqack) begin
        ack_at = cyc;
        break;
      end
    end
    check("ack_seen", 64'(ack_at >= 0), 64'd1);
    tick();
    sb.bus_reqcyc = 1'b0;
  endtask

  task automatic wait_free();
    int n;
    n = 0;
    while (mode != M_FREE && n < 400) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("done_in_time", 64'(mode == M_FREE), 64'd1);
  endtask

  task automatic read_line(input logic [63:0] a, input logic [12:0] t);
    clear_obs();
    send_beat(a, t, rd_ack_at);
    wait_free();
    $display("read  addr=%h tag=%h beats=%0d", a, t, obs_data.size());
  endtask

  task automatic write_line(input logic [63:0] a, input logic [12:0] t, input bit gapped,
                            input logic [63:0] d0, input bit rnd);
    int ack_at;
    send_beat(a, t, ack_at);
    for (int k = 0; k < 8; k++) begin
      if (gapped) tick();
      else if (rnd) repeat ($urandom_range(0, 2)) tick();
      send_beat(rnd ? {$urandom, $urandom} : d0 + 64'(k), 13'($urandom), ack_at);
    end
    $display("write addr=%h tag=%h", a, t);
  endtask

  task automatic check_beats(string name, logic [63:0] first, logic [12:0] t);
    check({name, "_count"}, 64'(obs_data.size()), 64'd8);
    for (int k = 0; k < 8; k++) begin
      check({name, "_data"}, obs_data[k], first + 64'(k));
      check({name, "_tag"}, 64'(obs_tag[k]), 64'(t));
    end
  endtask

  initial begin
    int ack_b, n;
    logic [63:0] a;
    int d;
    sb.bus_reqcyc = 1'b0; sb.bus_req = '0; sb.bus_reqtag = '0; sb.bus_respack = 1'b0;

    // Reset with a valid, matching request pending: no ack while reset is high
    reset = 1'b1;
    sb.bus_reqcyc = 1'b1; sb.bus_reqtag = 13'h1155; sb.bus_req = 64'h40;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_reqack", 64'(sb.bus_reqack), 64'd0);
    check("rst_respcyc", 64'(sb.bus_respcyc), 64'd0);
    check("rst_resp", sb.bus_resp, 64'd0);
    check("rst_resptag", 64'(sb.bus_resptag), 64'd0);
    tick();
    sb.bus_reqcyc = 1'b0;
    reset = 1'b0;

    for (int i = 0; i < WORDS; i++) pl_q.push_back({12'(i), $urandom, $urandom});
    for (int k = 0; k < 8; k++) pl_q.push_back({12'(8 + k), 64'h1000 + 64'(k)});
    while (pl_q.size() != 0) tick();
    tick();

    // Zero-stall read
    rp_mode = 0;
    read_line(64'h40, 13'h1155);
    check("t1_ack_cycles", 64'(obs_acks), 64'd1);
    check("t1_latency", 64'(first_rc - rd_ack_at), 64'(L));
    check("t1_window", 64'(rc_cycles), 64'd8);
    check_beats("t1", 64'h1000, 13'h1155);

    // Backpressure on beat 2
    rp_mode = 2; stall_cnt = 0;
    read_line(64'h40, 13'h1155);
    check("t2_window", 64'(rc_cycles), 64'd11);
    check("t2_hold", 64'(hold_cnt), 64'd4);
    check_beats("t2", 64'h1000, 13'h1155);
    rp_mode = 0;

    // Gapped write then readback
    clear_obs();
    write_line(64'h80, 13'h0100, 1'b1, 64'hA0, 1'b0);
    check("t3_acks", 64'(obs_acks), 64'd9);
    wait_free();
    read_line(64'h80, 13'h1103);
    check_beats("t3", 64'hA0, 13'h1103);

    // Foreign device is never acked
    clear_obs();
    sb.bus_reqcyc = 1'b1; sb.bus_reqtag = 13'h1255; sb.bus_req = 64'h40;
    repeat (20) @(negedge clk);
    check("t4_foreign_acks", 64'(obs_acks), 64'd0);
    tick();
    sb.bus_reqcyc = 1'b0;
    tick();
    $display("foreign tag=1255 held 20 cycles");

    // Busy: second request waits until after the last beat is acked
    clear_obs();
    send_beat(64'h40, 13'h1101, rd_ack_at);
    n = 0;
    while (!sb.bus_respcyc && n < 50) begin
      @(negedge clk);
      n++;
    end
    tick();
    send_beat(64'hC0, 13'h1102, ack_b);
    check("t4_busy_ack", 64'(ack_b), 64'(last_beat_cyc + 1));
    wait_free();
    $display("busy  second request acked at cycle %0d", ack_b);

    // Wrap and ignored low bits
    read_line(64'(WORDS * 8) + 64'h7F, 13'h1156);
    check_beats("t5", 64'h1000, 13'h1156);

    // Reset while beat 3 is on the bus
    clear_obs();
    send_beat(64'h40, 13'h1157, rd_ack_at);
    n = 0;
    while (!(mode == M_RD && acked == 3) && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("t6_reached_beat3", 64'(acked), 64'd3);
    @(posedge clk); #1; reset = 1'b1;
    @(posedge clk); #1; reset = 1'b0;
    @(negedge clk);
    check("t6_respcyc_after_reset", 64'(sb.bus_respcyc), 64'd0);
    tick();
    read_line(64'h40, 13'h1158);
    check_beats("t6", 64'h1000, 13'h1158);

    // Randomised traffic with random respack and backdoor writes into the active line
    rp_mode = 1; bd_rand = 1'b1;
    for (int t = 0; t < 40; t++) begin
      a = {$urandom, $urandom};
      case ($urandom_range(0, 4))
        0: begin
          d = int'($urandom_range(0, 14));
          if (d >= 1) d++;
          sb.bus_reqcyc = 1'b1; sb.bus_req = a;
          sb.bus_reqtag = {1'($urandom), 4'(d), 8'($urandom)};
          repeat (6) tick();
          sb.bus_reqcyc = 1'b0;
          tick();
          $display("foreign addr=%h dev=%0d", a, d);
        end
        1, 2: read_line(a, {5'b1_0001, 8'($urandom)});
        default: begin
          write_line(a, {5'b0_0001, 8'($urandom)}, 1'b0, 64'd0, 1'b1);
          wait_free();
        end
      endcase
    end
    bd_rand = 1'b0;
    repeat (4) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
